// File: rtl/vector_alu_sequencer.sv
// ---------------------------------------------------------------------------
// vector_alu_sequencer
//   Multi-word command sequencer for the packed 4x8-bit vector ALU. One
//   command at a time: for each word i it reads A[SRCA+i] and B[SRCB+i] from
//   a single-port synchronous memory, feeds the external combinational ALU,
//   and writes the (div-by-zero fixed) result to DST+i. Four cycles per word.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   CMD_VALID/CMD_READY   command handshake; READY is high only in IDLE
//   CMD_OP/SRCA/SRCB/DST  op code and base word addresses
//   CMD_LEN               words to process (0 allowed -> immediate DONE)
//   MEM_ADDR/WE/WDATA     memory request; MEM_RDATA valid one cycle later
//   ALU_IN0/IN1/OP        registered operands and latched op to the ALU
//   ALU_OUT               combinational ALU result
//   BUSY                  command in progress
//   DONE                  one-cycle completion pulse
//   DIVZ                  sticky div-by-zero flag for the last command
// ---------------------------------------------------------------------------

// Per-lane result fix-up: a divide lane whose divisor is zero reads as 8'hFF.
module vector_alu_sequencer_lane_fix #(
   parameter int VEC_W = 8
) (
   input  logic             is_div,
   input  logic [VEC_W-1:0] b,
   input  logic [VEC_W-1:0] alu,
   output logic [VEC_W-1:0] res,
   output logic             dz
);
   assign dz  = is_div && (b == '0);
   assign res = dz ? {VEC_W{1'b1}} : alu;
endmodule

module vector_alu_sequencer #(
   parameter int AW = 8,
   parameter int LW = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic [1:0]    CMD_OP,
   input  logic [AW-1:0] CMD_SRCA,
   input  logic [AW-1:0] CMD_SRCB,
   input  logic [AW-1:0] CMD_DST,
   input  logic [LW-1:0] CMD_LEN,
   output logic [AW-1:0] MEM_ADDR,
   output logic          MEM_WE,
   output logic [31:0]   MEM_WDATA,
   input  logic [31:0]   MEM_RDATA,
   output logic [31:0]   ALU_IN0,
   output logic [31:0]   ALU_IN1,
   output logic [1:0]    ALU_OP,
   input  logic [31:0]   ALU_OUT,
   output logic          BUSY,
   output logic          DONE,
   output logic          DIVZ
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic [2:0] {IDLE, RDA, RDB, LATB, WR} state_t;

   state_t        state, state_nxt;
   logic [1:0]    op_q;
   logic [AW-1:0] srca_q, srcb_q, dst_q;
   logic [LW-1:0] len_q, idx_q;
   logic [31:0]   a_q, b_q;
   logic          done_q, divz_q;

   logic          accept, last;
   logic [AW-1:0] idx_aw;

   logic [NUM_LANES-1:0][VEC_W-1:0] b_lanes, out_lanes, fix_lanes;
   logic [NUM_LANES-1:0]            dz_lane;

   assign accept = CMD_VALID && (state == IDLE);
   assign last   = (idx_q + LW'(1)) == len_q;
   assign idx_aw = AW'(idx_q);

   assign b_lanes   = b_q;
   assign out_lanes = ALU_OUT;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      vector_alu_sequencer_lane_fix #(.VEC_W(VEC_W)) u_fix (
         .is_div (op_q == 2'b11),
         .b      (b_lanes[l]),
         .alu    (out_lanes[l]),
         .res    (fix_lanes[l]),
         .dz     (dz_lane[l])
      );
   end

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and memory request
   always_comb begin
      state_nxt = state;
      CMD_READY = 1'b0;
      MEM_ADDR  = '0;
      MEM_WE    = 1'b0;
      MEM_WDATA = '0;
      case (state)
         IDLE: begin
            CMD_READY = 1'b1;
            // LEN=0 is accepted but never leaves IDLE
            if (CMD_VALID && (CMD_LEN != '0)) state_nxt = RDA;
         end
         RDA: begin
            MEM_ADDR  = srca_q + idx_aw;
            state_nxt = RDB;
         end
         RDB: begin
            MEM_ADDR  = srcb_q + idx_aw;
            state_nxt = LATB;
         end
         LATB: state_nxt = WR;
         WR: begin
            MEM_ADDR  = dst_q + idx_aw;
            MEM_WE    = 1'b1;
            MEM_WDATA = fix_lanes;
            state_nxt = last ? IDLE : RDA;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // command latch, operand registers, index, flags
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q   <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         done_q <= 1'b0;
         divz_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               op_q   <= CMD_OP;
               srca_q <= CMD_SRCA;
               srcb_q <= CMD_SRCB;
               dst_q  <= CMD_DST;
               len_q  <= CMD_LEN;
               idx_q  <= '0;
               divz_q <= 1'b0;
               if (CMD_LEN == '0) done_q <= 1'b1;
            end
            RDB:  a_q <= MEM_RDATA;   // data for the RDA address
            LATB: b_q <= MEM_RDATA;   // data for the RDB address
            WR: begin
               idx_q <= idx_q + LW'(1);
               if (|dz_lane) divz_q <= 1'b1;
               if (last)     done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ALU_IN0 = a_q;
   assign ALU_IN1 = b_q;
   assign ALU_OP  = op_q;
   assign BUSY    = (state != IDLE);
   assign DONE    = done_q;
   assign DIVZ    = divz_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
module tb_vector_alu_sequencer;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [1:0]  CMD_OP = '0;
   logic [7:0]  CMD_SRCA = '0, CMD_SRCB = '0, CMD_DST = '0, CMD_LEN = '0;
   logic [7:0]  MEM_ADDR;
   logic        MEM_WE;
   logic [31:0] MEM_WDATA, MEM_RDATA, ALU_IN0, ALU_IN1, ALU_OUT;
   logic [1:0]  ALU_OP;
   logic        BUSY, DONE, DIVZ;

   vector_alu_sequencer #(.AW(8), .LW(8)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_SRCA(CMD_SRCA), .CMD_SRCB(CMD_SRCB), .CMD_DST(CMD_DST), .CMD_LEN(CMD_LEN),
      .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
      .ALU_IN0(ALU_IN0), .ALU_IN1(ALU_IN1), .ALU_OP(ALU_OP), .ALU_OUT(ALU_OUT),
      .BUSY(BUSY), .DONE(DONE), .DIVZ(DIVZ)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // memory model with a bench preload port
   logic [31:0] mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   always @(posedge CLK) begin
      MEM_RDATA <= mem[MEM_ADDR];
      if (pre_we)      mem[pre_addr] <= pre_data;
      else if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
   end

   // ALU model; a zero divisor lane yields 0 here so the fix-up is visible
   function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, b);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) begin
         logic [7:0] x, y;
         x = a[l*8 +: 8];
         y = b[l*8 +: 8];
         case (op)
            2'b00: r[l*8 +: 8] = x + y;
            2'b01: r[l*8 +: 8] = x - y;
            2'b10: r[l*8 +: 8] = x * y;
            default: r[l*8 +: 8] = (y == 0) ? 8'h00 : x / y;
         endcase
      end
      return r;
   endfunction
   assign ALU_OUT = alu_f(ALU_OP, ALU_IN0, ALU_IN1);

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wexp_t;
   wexp_t wq[$];
   int    dq[$];

   task automatic push_w(input logic [7:0] a, input logic [31:0] d, input int c);
      wexp_t e;
      e.addr = a; e.data = d; e.cyc = c;
      wq.push_back(e);
   endtask

   // monitor: every write and every DONE must match the next expectation
   always @(negedge CLK) begin
      if (RST_N) begin
         if (MEM_WE) begin
            if (wq.size() == 0) chk("unexpected_write", {MEM_ADDR, MEM_WDATA}, 40'h0);
            else begin
               wexp_t e;
               e = wq.pop_front();
               chk("write_addr_data", {MEM_ADDR, MEM_WDATA}, {e.addr, e.data});
               chk("write_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (DONE) begin
            if (dq.size() == 0) chk("unexpected_done", 64'(cyc), 64'(0));
            else begin
               int c;
               c = dq.pop_front();
               chk("done_cycle", 64'(cyc), 64'(c));
            end
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge CLK);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge CLK);
      pre_we = 1'b0;
   endtask

   // returns c0 such that cycle k after the accept edge samples as cyc==c0+k
   task automatic send(input logic [1:0] op, input logic [7:0] a, b, d, len,
                       input bit hold, output int c0);
      int k;
      k = 0;
      @(negedge CLK);
      while (!CMD_READY && k < 200) begin @(negedge CLK); k++; end
      if (!CMD_READY) chk("ready_timeout", 64'(CMD_READY), 64'(1));
      CMD_OP = op; CMD_SRCA = a; CMD_SRCB = b; CMD_DST = d; CMD_LEN = len;
      CMD_VALID = 1'b1;
      c0 = cyc;
      if (!hold) begin
         @(negedge CLK);
         CMD_VALID = 1'b0;
      end
   endtask

   task automatic drain;
      int k;
      k = 0;
      while ((wq.size() != 0 || dq.size() != 0) && k < 200) begin @(negedge CLK); k++; end
      chk("drain", 64'(wq.size() + dq.size()), 64'(0));
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      int c0, c1, busy_err;

      // reset state
      #3;
      chk("reset_ctl", {CMD_READY, BUSY, DONE, DIVZ, MEM_WE, ALU_OP}, 7'b1000000);
      chk("reset_mem", {MEM_ADDR, MEM_WDATA}, 40'h0);
      chk("reset_alu", {ALU_IN0, ALU_IN1}, 64'h0);

      preload(8'h10, 32'h05060708);
      preload(8'h20, 32'h01020304);
      preload(8'h24, 32'h01000304);
      preload(8'h50, 32'h05060708); preload(8'h58, 32'h01020304);
      preload(8'h51, 32'h02020202); preload(8'h59, 32'h03030303);
      preload(8'h52, 32'h10101010); preload(8'h5A, 32'h10101010);
      preload(8'h40, 32'h05060708); preload(8'h41, 32'h01020304);
      @(negedge CLK);
      RST_N = 1'b1;

      // single-word add
      send(2'b00, 8'h10, 8'h20, 8'h30, 8'd1, 1'b0, c0);
      push_w(8'h30, 32'h06080A0C, c0 + 4);
      dq.push_back(c0 + 5);
      drain();
      chk("add_divz", 64'(DIVZ), 64'(0));

      // multi-word mul with BUSY window
      send(2'b10, 8'h50, 8'h58, 8'h5C, 8'd3, 1'b0, c0);
      push_w(8'h5C, 32'h050C1520, c0 + 4);
      push_w(8'h5D, 32'h06060606, c0 + 8);
      push_w(8'h5E, 32'h00000000, c0 + 12);
      dq.push_back(c0 + 13);
      busy_err = 0;
      for (int k = 1; k <= 13; k++) begin
         if (BUSY !== (k <= 12)) busy_err++;
         @(negedge CLK);
      end
      chk("mul_busy_window", 64'(busy_err), 64'(0));
      drain();

      // div with a zero lane, then a clean div clears DIVZ on accept
      send(2'b11, 8'h10, 8'h24, 8'h34, 8'd1, 1'b0, c0);
      push_w(8'h34, 32'h05FF0202, c0 + 4);
      dq.push_back(c0 + 5);
      drain();
      chk("divz_set", 64'(DIVZ), 64'(1));
      send(2'b11, 8'h10, 8'h20, 8'h35, 8'd1, 1'b0, c0);
      push_w(8'h35, 32'h05030202, c0 + 4);
      dq.push_back(c0 + 5);
      chk("divz_clear_on_accept", 64'(DIVZ), 64'(0));
      drain();
      chk("divz_clean", 64'(DIVZ), 64'(0));

      // LEN=0: DONE in cycle 1, BUSY stays low
      send(2'b00, 8'h10, 8'h20, 8'h36, 8'd0, 1'b0, c0);
      dq.push_back(c0 + 1);
      chk("len0_busy", {BUSY, MEM_WE}, 2'b00);
      drain();

      // back-to-back: VALID held, second command taken on the DONE cycle
      send(2'b01, 8'h40, 8'h41, 8'h42, 8'd1, 1'b1, c0);
      push_w(8'h42, 32'h04040404, c0 + 4);
      dq.push_back(c0 + 5);
      c1 = c0 + 5;
      push_w(8'h31, 32'h06080A0C, c1 + 4);
      dq.push_back(c1 + 5);
      @(negedge CLK);
      CMD_OP = 2'b00; CMD_SRCA = 8'h10; CMD_SRCB = 8'h20; CMD_DST = 8'h31; CMD_LEN = 8'd1;
      while (cyc < c0 + 6) @(negedge CLK);
      CMD_VALID = 1'b0;
      drain();

      // address wrap with in-place destination
      preload(8'hFF, 32'h11111111);
      preload(8'h00, 32'h01020304);
      preload(8'h01, 32'h10203040);
      send(2'b00, 8'hFF, 8'h00, 8'hFF, 8'd2, 1'b0, c0);
      push_w(8'hFF, 32'h12131415, c0 + 4);
      push_w(8'h00, 32'h11223344, c0 + 8);
      dq.push_back(c0 + 9);
      drain();

      // reset in cycle 6 of a LEN=3 command
      preload(8'h60, 32'h01010101); preload(8'h70, 32'h02020202);
      preload(8'h61, 32'h0A0B0C0D); preload(8'h71, 32'h01010101);
      preload(8'h81, 32'hDEADBEEF);
      send(2'b00, 8'h60, 8'h70, 8'h80, 8'd3, 1'b0, c0);
      push_w(8'h80, 32'h03030303, c0 + 4);
      while (cyc != c0 + 6) begin @(posedge CLK); #1; end
      #1 RST_N = 1'b0;
      #1;
      chk("abort_ctl", {CMD_READY, BUSY, DONE, DIVZ, MEM_WE, ALU_OP}, 7'b1000000);
      chk("abort_mem", {MEM_ADDR, MEM_WDATA}, 40'h0);
      chk("abort_alu", {ALU_IN0, ALU_IN1}, 64'h0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(negedge CLK);
      chk("abort_pending", 64'(wq.size() + dq.size()), 64'(0));
      chk("abort_word0", 64'(mem[8'h80]), 64'(32'h03030303));
      chk("abort_word1_untouched", 64'(mem[8'h81]), 64'(32'hDEADBEEF));
      send(2'b00, 8'h61, 8'h71, 8'h90, 8'd1, 1'b0, c0);
      push_w(8'h90, 32'h0B0C0D0E, c0 + 4);
      dq.push_back(c0 + 5);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
